// File: rtl/bch_loc_collector.sv
// bch_loc_collector: captures the error-location burst from the bch decoder,
// range-checks each location against the codeword length chosen by `code`,
// buffers up to DEPTH of them and replays them on a valid/ready stream.
// Optional build macro: LOC_SORT_EN -- when defined, each stored location is
// insertion-placed so the replay comes out in ascending order; when undefined
// the replay keeps arrival order and no comparator network is built.
//
// Output handshake: o_valid/o_loc/o_last are registered. Once o_valid is high
// it stays high and o_loc/o_last hold until the edge where o_ready is also
// high; that edge is the transfer. o_valid never depends on o_ready.
module bch_loc_collector #(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          set,
  input  logic [1:0]    code,
  input  logic          finish,
  input  logic [AW-1:0] odata,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [AW-1:0] o_loc,
  output logic          o_last,
  output logic [2:0]    o_cnt,
  output logic          o_done,
  output logic          o_rng_err,
  output logic          o_ovf,
  output logic          busy,
  output logic [1:0]    o_dbg_state
);

  // Count/pointer width; o_cnt is fixed at 3 bits, so with DEPTH=8 a full
  // buffer reads back as 0 on that port while the internal count stays exact.
  localparam int CW = $clog2(DEPTH + 1);
  // Limit is one bit wider than a location so "range check off" (2**AW) fits.
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [LW-1:0]   r_limit;
  logic [LW-1:0]   w_set_limit;
  logic [LW-1:0]   w_limit;
  logic            r_rng_err;
  logic            r_ovf;

  logic [AW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   w_mem_nxt [DEPTH];
  logic [CW-1:0]   r_cnt;

  logic            r_valid;
  logic [AW-1:0]   r_loc;
  logic            r_last;
  logic [CW-1:0]   r_rd;
  logic [CW-1:0]   w_rd_nxt;
  logic [AW-1:0]   w_head_nxt;
  logic            r_done;

  logic            w_cap;
  logic            w_enter_drain;
  logic            w_empty_end;
  logic            w_last_xfer;
  logic            w_xfer;
  logic            w_in_rng;
  logic            w_full;
  logic            w_store;
  logic            w_rng_hit;
  logic            w_ovf_hit;

  // Decode the code select into an exclusive upper bound for locations.
  always_comb begin
    w_set_limit = LW'(2**AW);
    case (code)
      2'd1:    w_set_limit = LW'(63);
      2'd2:    w_set_limit = LW'(255);
      2'd3:    w_set_limit = LW'(1023);
      default: w_set_limit = LW'(2**AW);
    endcase
  end

  // A set in the same cycle as a word applies its limit to that word.
  assign w_limit   = set ? w_set_limit : r_limit;
  assign w_xfer    = r_valid && o_ready;
  assign w_in_rng  = {1'b0, odata} < w_limit;
  assign w_full    = (r_cnt == CW'(DEPTH));
  assign w_store   = w_cap && w_in_rng && !w_full;
  assign w_rng_hit = w_cap && !w_in_rng;
  assign w_ovf_hit = (w_cap && w_in_rng && w_full) ||
                     ((r_state == S_DRAIN) && finish);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic and the per-cycle control strobes.
  always_comb begin
    w_state_nxt   = r_state;
    w_cap         = 1'b0;
    w_enter_drain = 1'b0;
    w_empty_end   = 1'b0;
    w_last_xfer   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (finish) begin
          w_cap       = 1'b1;
          w_state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (finish) begin
          w_cap = 1'b1;
        end else if (r_cnt != '0) begin
          w_enter_drain = 1'b1;
          w_state_nxt   = S_DRAIN;
        end else begin
          w_empty_end = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (w_xfer && r_last) begin
          w_last_xfer = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef LOC_SORT_EN
  logic [CW-1:0] w_pos;

  // Insertion point: count of stored entries <= the new word, so an equal
  // location lands right after its twin.
  always_comb begin
    w_pos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_cnt) && (r_mem[i] <= odata)) w_pos = w_pos + CW'(1);
    end
  end

  // Shift everything at or above the insertion point up by one slot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < w_pos)       w_mem_nxt[i] = r_mem[i];
      else if (CW'(i) == w_pos) w_mem_nxt[i] = odata;
      else                      w_mem_nxt[i] = r_mem[(i > 0) ? i - 1 : 0];
    end
  end
`else
  // Arrival order: the new word goes into the next free slot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_mem_nxt[i] = (CW'(i) == r_cnt) ? odata : r_mem[i];
    end
  end
`endif

  // Buffer contents and entry count; the count clears when the last entry leaves.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mem <= '{default: '0};
      r_cnt <= '0;
    end else if (w_last_xfer) begin
      r_cnt <= '0;
    end else if (w_store) begin
      r_mem <= w_mem_nxt;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Limit latch and the two sticky flags; a hit in the set cycle wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_limit   <= LW'(2**AW);
      r_rng_err <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (set) r_limit <= w_set_limit;
      if (w_rng_hit)  r_rng_err <= 1'b1;
      else if (set)   r_rng_err <= 1'b0;
      if (w_ovf_hit)  r_ovf <= 1'b1;
      else if (set)   r_ovf <= 1'b0;
    end
  end

  // Entry selected after a transfer (the buffer is already in output order).
  assign w_rd_nxt = r_rd + CW'(1);
  always_comb begin
    w_head_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) == w_rd_nxt) w_head_nxt = r_mem[i];
    end
  end

  // Registered output stage: loads the head on DRAIN entry, advances per transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_loc   <= '0;
      r_last  <= 1'b0;
      r_rd    <= '0;
    end else if (w_enter_drain) begin
      r_valid <= 1'b1;
      r_loc   <= r_mem[0];
      r_last  <= (r_cnt == CW'(1));
      r_rd    <= '0;
    end else if (w_last_xfer) begin
      r_valid <= 1'b0;
      r_loc   <= '0;
      r_last  <= 1'b0;
      r_rd    <= '0;
    end else if (w_xfer) begin
      r_rd    <= w_rd_nxt;
      r_loc   <= w_head_nxt;
      r_last  <= (w_rd_nxt == r_cnt - CW'(1));
    end
  end

  // Completion pulse: after the last transfer, or when a burst stored nothing.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_done <= 1'b0;
    else       r_done <= w_empty_end || w_last_xfer;
  end

  assign o_valid     = r_valid;
  assign o_loc       = r_loc;
  assign o_last      = r_last;
  assign o_cnt       = 3'(r_cnt);
  assign o_done      = r_done;
  assign o_rng_err   = r_rng_err;
  assign o_ovf       = r_ovf;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule
